// File: rtl/mem_latency_pipeline_pkg.sv
// Shared level encodings and default base latencies for the GPGPU memory-latency model.
package mem_latency_pipeline_pkg;

    typedef enum logic [1:0] {
        LVL_SHARED = 2'd0,
        LVL_L1     = 2'd1,
        LVL_L2     = 2'd2,
        LVL_DRAM   = 2'd3
    } level_e;

    localparam int DEF_NUM_SEG     = 8;
    localparam int DEF_SEG_W       = 3;
    localparam int DEF_DEPTH       = 8;
    localparam int DEF_TAG_W       = 6;
    localparam int DEF_LAT_W       = 10;
    localparam int DEF_SHARED_LAT  = 1;
    localparam int DEF_L1_LAT      = 1;
    localparam int DEF_L2_LAT      = 20;
    localparam int DEF_DRAM_LAT    = 400;
    localparam int DEF_SEG_PENALTY = 0;

endpackage

// File: rtl/mem_latency_calc.sv
// Combinational latency lookup: base(level) + per-segment penalty, saturated to
// the timer width and clamped to a minimum of one cycle.
module mem_latency_calc
    import mem_latency_pipeline_pkg::*;
#(
    parameter int SEG_W       = DEF_SEG_W,
    parameter int LAT_W       = DEF_LAT_W,
    parameter int SHARED_LAT  = DEF_SHARED_LAT,
    parameter int L1_LAT      = DEF_L1_LAT,
    parameter int L2_LAT      = DEF_L2_LAT,
    parameter int DRAM_LAT    = DEF_DRAM_LAT,
    parameter int SEG_PENALTY = DEF_SEG_PENALTY
) (
    input  logic [1:0]       level,
    input  logic [SEG_W-1:0] seg,
    output logic [LAT_W-1:0] lat
);

    // Wide enough that base + penalty*seg never wraps before the saturation test.
    localparam int CW = LAT_W + SEG_W + 1;
    localparam logic [CW-1:0] LAT_MAX = {{(SEG_W + 1){1'b0}}, {LAT_W{1'b1}}};

    logic [CW-1:0] base;
    logic [CW-1:0] sum;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        base = CW'(SHARED_LAT);
        sum  = '0;
        lat  = '0;
        case (level_e'(level))
            LVL_SHARED: base = CW'(SHARED_LAT);
            LVL_L1:     base = CW'(L1_LAT);
            LVL_L2:     base = CW'(L2_LAT);
            LVL_DRAM:   base = CW'(DRAM_LAT);
            default:    base = CW'(SHARED_LAT);
        endcase
        sum = base + CW'(SEG_PENALTY) * CW'(seg);
        if (sum > LAT_MAX) begin
            lat = '1;
        end else if (sum == '0) begin
            lat = LAT_W'(1);
        end else begin
            lat = sum[LAT_W-1:0];
        end
    end

endmodule

// File: rtl/mem_latency_pipeline.sv
// In-order outstanding-request buffer: each entry counts down its modelled
// latency and is returned with its tag once it reaches the head and matures.
module mem_latency_pipeline
    import mem_latency_pipeline_pkg::*;
#(
    parameter int NUM_SEG     = DEF_NUM_SEG,
    parameter int SEG_W       = DEF_SEG_W,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int TAG_W       = DEF_TAG_W,
    parameter int LAT_W       = DEF_LAT_W,
    parameter int SHARED_LAT  = DEF_SHARED_LAT,
    parameter int L1_LAT      = DEF_L1_LAT,
    parameter int L2_LAT      = DEF_L2_LAT,
    parameter int DRAM_LAT    = DEF_DRAM_LAT,
    parameter int SEG_PENALTY = DEF_SEG_PENALTY
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [SEG_W-1:0]           req_seg,
    input  logic [1:0]                 req_level,
    input  logic [TAG_W-1:0]           req_tag,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [TAG_W-1:0]           rsp_tag,
    output logic [SEG_W-1:0]           rsp_seg,
    output logic [1:0]                 rsp_level,
    output logic [LAT_W-1:0]           delay,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [TAG_W-1:0] tag_q   [DEPTH];
    logic [SEG_W-1:0] seg_q   [DEPTH];
    logic [1:0]       level_q [DEPTH];
    logic [LAT_W-1:0] timer_q [DEPTH];
    logic [DEPTH-1:0] live_q;

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [LAT_W-1:0] lat;
    logic             push;
    logic             pop;

    mem_latency_calc #(
        .SEG_W      (SEG_W),
        .LAT_W      (LAT_W),
        .SHARED_LAT (SHARED_LAT),
        .L1_LAT     (L1_LAT),
        .L2_LAT     (L2_LAT),
        .DRAM_LAT   (DRAM_LAT),
        .SEG_PENALTY(SEG_PENALTY)
    ) u_calc (
        .level(req_level),
        .seg  (req_seg),
        .lat  (lat)
    );

    // Readiness looks only at the registered count: a same-cycle pop never frees a slot.
    assign req_ready = (count < FULL_CNT) & ~stall & ~reset;
    assign rsp_valid = (count != '0) & (timer_q[rd_ptr] == '0) & ~stall;
    assign push      = req_valid & req_ready;
    assign pop       = rsp_valid & rsp_ready;

    assign rsp_tag   = tag_q[rd_ptr];
    assign rsp_seg   = seg_q[rd_ptr];
    assign rsp_level = level_q[rd_ptr];
    assign occupancy = count;

    // NOTE: the payload array is deliberately not reset; it is only observed through a live entry, which reset already clears.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_q[wr_ptr]   <= req_tag;
            seg_q[wr_ptr]   <= req_seg;
            level_q[wr_ptr] <= req_level;
        end
    end

    // NOTE: state uses non-blocking assignment so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                timer_q[i] <= '0;
            end
            live_q <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            delay  <= '0;
        end else begin
            // Followers keep counting behind a blocked head so they can drain back-to-back.
            if (!stall) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (live_q[i] && timer_q[i] != '0) begin
                        timer_q[i] <= timer_q[i] - LAT_W'(1);
                    end
                end
            end
            if (pop) begin
                live_q[rd_ptr] <= 1'b0;
                rd_ptr         <= rd_ptr + PTR_W'(1);
            end
            if (push) begin
                live_q[wr_ptr]  <= 1'b1;
                timer_q[wr_ptr] <= lat - LAT_W'(1);
                wr_ptr          <= wr_ptr + PTR_W'(1);
                delay           <= lat;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
